// File: rtl/pulse_pkg.sv
// Shared definitions for the reference pulse path: FSM state encoding and a
// counter-width helper used by the filter and holdoff counters.
package pulse_pkg;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_ARMED   = 2'd1;
    localparam logic [1:0] ENC_HOLDOFF = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = ENC_IDLE,
        ST_ARMED   = ENC_ARMED,
        ST_HOLDOFF = ENC_HOLDOFF
    } pulse_state_e;

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output level only
// changes after the synchronized input has held the new level FILT_LEN cycles.
module glitch_filter
    import pulse_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic alg_clk,
    input  logic alg_rst,
    input  logic din,
    output logic dout
);

    localparam int            CNT_W    = cnt_width(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge alg_clk) begin
        if (alg_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            // The FILT_LEN-th consecutive differing sample flips the level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign dout = r_level;

endmodule

// File: rtl/ref_pulse_gen.sv
// Turns the asynchronous chopper reference into rate-limited single-cycle pulses,
// measures the spacing between accepted pulses and flags a lost reference.
//
// state   | meaning
// IDLE    | disabled; counters, first-pulse flag and ref_lost held clear
// ARMED   | next candidate rising edge is accepted and emitted as a pulse
// HOLDOFF | HOLDOFF cycles after a pulse; candidate edges are dropped
module ref_pulse_gen
    import pulse_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int HOLDOFF  = 1000,
    parameter int PERIOD_W = 24,
    parameter int TIMEOUT  = 2000000
) (
    input  logic                alg_clk,
    input  logic                alg_rst,
    input  logic                ref_in,
    input  logic                enable,
    output logic                pulse_out,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid,
    output logic                ref_lost
);

    localparam int                HOLD_W    = cnt_width(HOLDOFF);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [PERIOD_W-1:0] PER_MAX = '1;
    localparam logic [PERIOD_W-1:0] TO_VAL  = PERIOD_W'(TIMEOUT);

    logic                w_filt;
    logic                r_filt_d;
    logic                r_cand;

    pulse_state_e        r_state;
    logic                r_pulse;
    logic                r_pvalid;
    logic [PERIOD_W-1:0] r_period;
    logic                r_lost;
    logic [PERIOD_W-1:0] r_cnt;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_first;

    glitch_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .alg_clk (alg_clk),
        .alg_rst (alg_rst),
        .din     (ref_in),
        .dout    (w_filt)
    );

    // Candidate edge is registered so the ref_in-to-pulse latency is a fixed
    // FILT_LEN+3 cycles regardless of FSM state.
    always_ff @(posedge alg_clk) begin
        if (alg_rst) begin
            r_filt_d <= 1'b0;
            r_cand   <= 1'b0;
        end else begin
            r_filt_d <= w_filt;
            r_cand   <= w_filt & ~r_filt_d;
        end
    end

    always_ff @(posedge alg_clk) begin
        if (alg_rst) begin
            r_state  <= ST_IDLE;
            r_pulse  <= 1'b0;
            r_pvalid <= 1'b0;
            r_period <= '0;
            r_lost   <= 1'b0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_first  <= 1'b0;
        end else if (!enable) begin
            r_state  <= ST_IDLE;
            r_pulse  <= 1'b0;
            r_pvalid <= 1'b0;
            r_lost   <= 1'b0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_first  <= 1'b0;
        end else begin
            r_pulse  <= 1'b0;
            r_pvalid <= 1'b0;

            if (r_state != ST_IDLE) begin
                if (r_cnt != PER_MAX) begin
                    r_cnt <= r_cnt + PERIOD_W'(1);
                end
                if (r_cnt == TO_VAL) begin
                    r_lost <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    // Assignments here override the free-running updates above.
                    if (r_cand) begin
                        r_pulse <= 1'b1;
                        r_state <= ST_HOLDOFF;
                        r_hold  <= '0;
                        r_cnt   <= PERIOD_W'(1);
                        r_lost  <= 1'b0;
                        r_first <= 1'b1;
                        if (r_first) begin
                            r_period <= r_cnt;
                            r_pvalid <= 1'b1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state <= ST_ARMED;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pulse_out    = r_pulse;
    assign period_valid = r_pvalid;
    assign period_out   = r_period;
    assign ref_lost     = r_lost;

endmodule

// File: tb/tb_ref_pulse_gen.sv
// Directed bench for ref_pulse_gen: stimulus pushes expected pulses into a
// scoreboard queue, a negedge monitor pops and compares each observed pulse.
module tb_ref_pulse_gen;

    localparam int FILT_LEN = 4;
    localparam int HOLDOFF  = 8;
    localparam int PERIOD_W = 8;
    localparam int TIMEOUT  = 50;
    // Input driven at the negedge of cycle t is first sampled at edge t+1,
    // so the pulse is seen after edge t+1+FILT_LEN+3.
    localparam int LAT      = FILT_LEN + 4;

    logic                alg_clk = 1'b0;
    logic                alg_rst = 1'b1;
    logic                ref_in  = 1'b0;
    logic                enable  = 1'b0;
    logic                pulse_out;
    logic [PERIOD_W-1:0] period_out;
    logic                period_valid;
    logic                ref_lost;

    ref_pulse_gen #(
        .FILT_LEN (FILT_LEN),
        .HOLDOFF  (HOLDOFF),
        .PERIOD_W (PERIOD_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .alg_clk      (alg_clk),
        .alg_rst      (alg_rst),
        .ref_in       (ref_in),
        .enable       (enable),
        .pulse_out    (pulse_out),
        .period_out   (period_out),
        .period_valid (period_valid),
        .ref_lost     (ref_lost)
    );

    always #5 alg_clk = ~alg_clk;

    int cyc = 0;
    always @(posedge alg_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit pv;
        int per;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_p = 0;
    bit   glitch_mon = 1'b0;
    bit   filt_seen  = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor
    always @(negedge alg_clk) begin
        if (pulse_out) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", int'(pulse_out), 0);
            end else begin
                m_e = sb_q.pop_front();
                check("pulse_cycle", cyc, m_e.cyc);
                check("period_valid", int'(period_valid), int'(m_e.pv));
                if (m_e.pv) check("period_out", int'(period_out), m_e.per);
                check("ref_lost_at_pulse", int'(ref_lost), 0);
            end
        end else if (period_valid) begin
            check("period_valid_without_pulse", int'(period_valid), 0);
        end
        if (glitch_mon && dut.w_filt) filt_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge alg_clk);
    endtask

    task automatic hold(input bit v, input int n);
        @(negedge alg_clk);
        ref_in = v;
        repeat (n - 1) @(negedge alg_clk);
    endtask

    task automatic push_exp(input int c, input bit pv, input int per);
        exp_t e;
        e.cyc = c;
        e.pv  = pv;
        e.per = per;
        sb_q.push_back(e);
        last_p = c;
    endtask

    // per < 0: expected period is the elapsed count since the last accepted
    // pulse, saturated at the 8-bit maximum.
    task automatic pulse_in(input int n_hi, input int n_lo, input bit acc,
                            input bit pv, input int per);
        int t;
        int p;
        @(negedge alg_clk);
        ref_in = 1'b1;
        t = cyc;
        if (acc) begin
            p = per;
            if (per < 0) p = ((t + LAT - last_p) > 255) ? 255 : (t + LAT - last_p);
            push_exp(t + LAT, pv, p);
        end
        repeat (n_hi - 1) @(negedge alg_clk);
        hold(1'b0, n_lo);
    endtask

    task automatic restart();
        @(negedge alg_clk);
        enable = 1'b0;
        ref_in = 1'b0;
        repeat (3) @(negedge alg_clk);
        enable = 1'b1;
    endtask

    initial begin
        int t;
        int te;

        repeat (3) @(negedge alg_clk);
        check("rst_pulse_out", int'(pulse_out), 0);
        check("rst_period_valid", int'(period_valid), 0);
        check("rst_period_out", int'(period_out), 0);
        check("rst_ref_lost", int'(ref_lost), 0);
        alg_rst = 1'b0;

        // Latency and single-cycle width
        restart();
        hold(1'b0, 10);
        pulse_in(20, 10, 1'b1, 1'b0, 0);

        // Glitch rejection: 3 high / 5 low never passes the filter
        restart();
        hold(1'b0, 10);
        glitch_mon = 1'b1;
        repeat (10) begin
            hold(1'b1, 3);
            hold(1'b0, 5);
        end
        glitch_mon = 1'b0;
        check("glitch_filt_level", int'(filt_seen), 0);

        // Holdoff: edges 8 apart -> every other accepted, period 16
        restart();
        hold(1'b0, 10);
        for (int k = 0; k < 6; k++) begin
            pulse_in(4, 4, (k % 2) == 0, k > 0, 16);
        end
        hold(1'b0, 10);

        // Holdoff boundary: edges 9 apart -> all accepted
        restart();
        hold(1'b0, 10);
        for (int k = 0; k < 4; k++) begin
            pulse_in(4, 5, 1'b1, k > 0, 9);
        end
        hold(1'b0, 10);

        // Period measurement on a 20-cycle square wave
        restart();
        hold(1'b0, 10);
        for (int k = 0; k < 4; k++) begin
            pulse_in(10, 10, 1'b1, k > 0, 20);
        end

        // Timeout with no pulse since enable, then after a pulse, then saturation
        restart();
        te = cyc;
        wait_cyc(te + 51);
        check("lost_from_enable_early", int'(ref_lost), 0);
        wait_cyc(te + 52);
        check("lost_from_enable", int'(ref_lost), 1);
        pulse_in(10, 10, 1'b1, 1'b0, 0);
        wait_cyc(last_p + 49);
        check("lost_after_pulse_early", int'(ref_lost), 0);
        wait_cyc(last_p + 50);
        check("lost_after_pulse", int'(ref_lost), 1);
        wait_cyc(last_p + 70);
        check("lost_still_set", int'(ref_lost), 1);
        pulse_in(10, 10, 1'b1, 1'b1, -1);
        wait_cyc(last_p + 300);
        pulse_in(10, 10, 1'b1, 1'b1, -1);

        // Enable drops during holdoff
        restart();
        hold(1'b0, 10);
        @(negedge alg_clk);
        ref_in = 1'b1;
        t = cyc;
        push_exp(t + LAT, 1'b0, 0);
        wait_cyc(t + 10);
        enable = 1'b0;
        wait_cyc(t + 14);
        ref_in = 1'b0;
        hold(1'b0, 8);
        repeat (3) pulse_in(6, 6, 1'b0, 1'b0, 0);
        wait_cyc(cyc + 60);
        check("lost_held_in_idle", int'(ref_lost), 0);

        // Enable falls on the candidate cycle, then re-enable with input high
        enable = 1'b1;
        hold(1'b0, 5);
        @(negedge alg_clk);
        ref_in = 1'b1;
        t = cyc;
        wait_cyc(t + 7);
        enable = 1'b0;
        wait_cyc(t + 15);
        enable = 1'b1;
        wait_cyc(t + 40);
        hold(1'b0, 10);
        pulse_in(10, 10, 1'b1, 1'b0, 0);
        pulse_in(10, 10, 1'b1, 1'b1, 20);

        // Reset mid-period
        hold(1'b0, 5);
        @(negedge alg_clk);
        alg_rst = 1'b1;
        @(negedge alg_clk);
        alg_rst = 1'b0;
        check("midrst_pulse_out", int'(pulse_out), 0);
        check("midrst_period_valid", int'(period_valid), 0);
        check("midrst_period_out", int'(period_out), 0);
        check("midrst_ref_lost", int'(ref_lost), 0);
        hold(1'b0, 10);
        pulse_in(10, 10, 1'b1, 1'b0, 0);
        pulse_in(10, 10, 1'b1, 1'b1, 20);

        hold(1'b0, 20);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
